bcd_to_bin_seq: RTL and testbench

Sequential BCD-to-binary converter built on the reverse double-dabble algorithm (shift right, subtract 3). It is the decode-direction companion to the BCD arithmetic path: packed BCD results from the BCD adder chain are turned back into plain binary for downstream logic. Conversion takes one shift per output bit, with a start/busy/done handshake and an invalid-digit error flag.

---
 rtl/bcd_to_bin_seq.sv | 137 +++++++++++++
 tb/tb_bcd_to_bin_seq.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_to_bin_seq.sv
// rtl/bcd_to_bin_seq.sv - sequential BCD-to-binary converter (reverse double dabble)
//
// Purpose: converts a packed BCD word to plain binary. Each CONV cycle does
// one right shift plus a subtract-3 correction, so a conversion takes BIN_W
// shifts. A start/busy/done handshake frames each conversion, and an
// invalid-digit flag reports any input digit above 9.
//
// Ports:
//   clk      - single clock, rising edge
//   rst_n    - asynchronous active-low reset
//   start    - conversion request, sampled only in IDLE
//   bcd_in   - packed BCD input, digit 0 in bits [3:0]
//   busy     - high while converting
//   done     - one-cycle pulse; bin_out/err are valid from this cycle on
//   bin_out  - converted value, held until replaced by a later result
//   err      - the last accepted input contained a digit > 9

module bcd_to_bin_seq #(
   parameter int DIGITS = 4,
   parameter int BIN_W  = 14
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic                  busy,
   output logic                  done,
   output logic [BIN_W-1:0]      bin_out,
   output logic                  err
);

   localparam int BCD_W = 4 * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);

   function automatic longint unsigned pow10(input int n);
      longint unsigned p;
      p = 1;
      for (int i = 0; i < n; i++) p = p * 10;
      return p;
   endfunction

   // The largest DIGITS-digit decimal value must fit in BIN_W bits.
   if (pow10(DIGITS) - 1 >= (64'd1 << BIN_W)) begin : g_bad_width
      $error("bcd_to_bin_seq: BIN_W too small for DIGITS");
   end

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CONV = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t             r_state;
   logic [BCD_W-1:0]   r_bcd;
   logic [BIN_W-1:0]   r_bin;
   logic [CNT_W-1:0]   r_cnt;

   logic [BCD_W-1:0]   w_bcd_shift;
   logic [BCD_W-1:0]   w_bcd_next;
   logic [BIN_W-1:0]   w_bin_next;
   logic               w_in_bad;
   logic               w_last;

   assign w_bcd_shift = {1'b0, r_bcd[BCD_W-1:1]};
   assign w_bin_next  = {r_bcd[0], r_bin[BIN_W-1:1]};
   assign w_last      = (r_cnt == CNT_W'(BIN_W - 1));

   // Post-shift correction: a digit that received a 1 from the digit above
   // reads >= 8 and is pulled back by 3, undoing the decimal weight of 10.
   always_comb begin
      w_bcd_next = w_bcd_shift;
      for (int d = 0; d < DIGITS; d++) begin
         if (w_bcd_shift[4*d+3])
            w_bcd_next[4*d +: 4] = w_bcd_shift[4*d +: 4] - 4'd3;
      end
   end

   always_comb begin
      w_in_bad = 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
         if (bcd_in[4*d +: 4] > 4'd9) w_in_bad = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_bcd   <= '0;
         r_bin   <= '0;
         r_cnt   <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         bin_out <= '0;
         err     <= 1'b0;
      end else begin
         // done is the registered image of the DONE state, so it rises one
         // edge after DONE is entered and overlaps the following IDLE cycle.
         done <= (r_state == S_DONE);
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  if (w_in_bad) begin
                     err     <= 1'b1;
                     bin_out <= '0;
                     r_state <= S_DONE;
                  end else begin
                     r_bcd   <= bcd_in;
                     r_bin   <= '0;
                     r_cnt   <= '0;
                     err     <= 1'b0;
                     busy    <= 1'b1;
                     r_state <= S_CONV;
                  end
               end
            end
            S_CONV: begin
               r_bcd <= w_bcd_next;
               r_bin <= w_bin_next;
               r_cnt <= r_cnt + CNT_W'(1);
               if (w_last) begin
                  bin_out <= w_bin_next;
                  busy    <= 1'b0;
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
            end
            default: begin
               busy    <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_to_bin_seq.sv
// tb/tb_bcd_to_bin_seq.sv - scoreboard testbench for bcd_to_bin_seq

module tb_bcd_to_bin_seq;

   localparam int DIGITS = 4;
   localparam int BIN_W  = 14;

   logic                clk;
   logic                rst_n;
   logic                start;
   logic [4*DIGITS-1:0] bcd_in;
   logic                busy;
   logic                done;
   logic [BIN_W-1:0]    bin_out;
   logic                err;

   bcd_to_bin_seq #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .bcd_in  (bcd_in),
      .busy    (busy),
      .done    (done),
      .bin_out (bin_out),
      .err     (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int bin;
      bit err;
      int cyc;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cyc   = 0;
   int   busy_cnt = 0;
   exp_t e;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp_v);
      n_cmp++;
      if (act != exp_v) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
      end
   endtask

   // Reference: decimal value of the packed digits; any digit > 9 is an error.
   function automatic void ref_model(input logic [15:0] v, output int val, output bit bad);
      int w;
      logic [15:0] t;
      t = v;
      val = 0;
      bad = 0;
      w = 1;
      for (int i = 0; i < DIGITS; i++) begin
         if (t[3:0] > 4'd9) bad = 1;
         val = val + int'(t[3:0]) * w;
         w = w * 10;
         t = t >> 4;
      end
      if (bad) val = 0;
   endfunction

   function automatic logic [15:0] to_bcd(input int n);
      logic [15:0] r;
      int x;
      x = n;
      r = '0;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   // Monitor: pops one expectation per done pulse.
   always @(negedge clk) begin
      if (!rst_n) begin
         busy_cnt = 0;
      end else begin
         if (busy) busy_cnt++;
         if (done) begin
            if (q.size() == 0) begin
               chk("done_unexpected", 1, 0);
            end else begin
               e = q.pop_front();
               chk("bin_out", bin_out, e.bin);
               chk("err", err, e.err);
               chk("latency", cyc - e.cyc, e.err ? 1 : BIN_W + 1);
               chk("busy_cycles", busy_cnt, e.err ? 0 : BIN_W);
               chk("busy_with_done", busy, 0);
            end
            busy_cnt = 0;
         end
      end
   end

   task automatic issue(input logic [15:0] v);
      exp_t x;
      int   val;
      bit   bad;
      bcd_in = v;
      start  = 1'b1;
      @(posedge clk);
      #1;
      ref_model(v, val, bad);
      x.bin = val;
      x.err = bad;
      x.cyc = cyc;
      q.push_back(x);
   endtask

   task automatic wait_done();
      bit got;
      got = 0;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk);
         #1;
         if (done) begin
            got = 1;
            break;
         end
      end
      if (!got) chk("done_timeout", 0, 1);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [15:0] v;
      int gap;
      rst_n  = 1'b1;
      start  = 1'b0;
      bcd_in = '0;
      #1 rst_n = 1'b0;
      #2;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_bin", bin_out, 0);
      chk("rst_err", err, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);

      // Maximum value, one-cycle start.
      issue(16'h9999);
      start = 1'b0;
      bcd_in = 16'hFFFF;
      wait_done();
      idle(2);

      issue(16'h1234);
      start = 1'b0;
      wait_done();
      idle(4);
      chk("hold_1234", bin_out, 1234);
      chk("hold_1234_err", err, 0);

      issue(16'h0000);
      start = 1'b0;
      wait_done();
      idle(3);
      chk("hold_0", bin_out, 0);

      // Invalid digit, then valid input clears err.
      issue(16'h12A4);
      start = 1'b0;
      wait_done();
      idle(2);
      chk("hold_err", err, 1);
      issue(16'h0042);
      start = 1'b0;
      wait_done();
      idle(2);

      // start pulse in the middle of CONV must be ignored.
      issue(16'h2468);
      start = 1'b0;
      idle(4);
      bcd_in = 16'h1111;
      start  = 1'b1;
      idle(1);
      start  = 1'b0;
      wait_done();
      idle(20);
      chk("mid_start_ignored", q.size(), 0);

      // Reset in the middle of a conversion.
      bcd_in = 16'h5678;
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
      idle(6);
      chk("abort_busy_before", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_bin", bin_out, 0);
      chk("abort_err", err, 0);
      idle(3);
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      chk("abort_bin_after", bin_out, 0);
      issue(16'h5678);
      start = 1'b0;
      wait_done();
      idle(2);

      // Random sweep with gaps and held start.
      for (int n = 0; n < 1800; n++) begin
         v = to_bcd($urandom_range(0, 9999));
         if ($urandom_range(0, 15) == 0)
            v[4*$urandom_range(0, DIGITS-1) +: 4] = 4'($urandom_range(10, 15));
         gap = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
         issue(v);
         start  = (gap == 0);
         bcd_in = 16'($urandom);
         wait_done();
         if (gap > 0) begin
            start = 1'b0;
            idle(gap);
         end
      end
      start = 1'b0;
      idle(40);
      chk("queue_drained", q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
